// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: spreads one valid/ready job stream over N sinks,
// each sink holding its own one-entry output register.
module rr_dispatcher #(
  parameter  int N  = 8,
  parameter  int DW = 8,
  localparam int M  = $clog2(N)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  input  logic [DW-1:0]          i_data,
  output logic                   o_ready,
  input  logic [N-1:0]           i_mask,
  output logic [N-1:0]           o_valid,
  output logic [N-1:0][DW-1:0]   o_data,
  input  logic [N-1:0]           i_ready,
  output logic [M-1:0]           o_dest
);

  logic [N-1:0]         r_valid;
  logic [N-1:0][DW-1:0] r_data;
  logic [M-1:0]         r_dest;
  logic [M-1:0]         r_ptr;

  logic [N-1:0] w_elig;
  logic         w_accept;
  logic         w_found;
  logic [M:0]   w_idx;
  logic [M-1:0] w_win;
  logic [M-1:0] w_ptrNext;

  // Only registered state and the mask feed eligibility, so o_ready never
  // depends on i_valid or i_ready.
  assign w_elig   = ~r_valid & ~i_mask;
  assign o_ready  = i_rstn & (|w_elig);
  assign w_accept = i_valid & o_ready;

  // Scan from the pointer upward with an explicit modulo-N wrap, which keeps
  // the search correct when N is not a power of two.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, r_ptr} + (M+1)'(i);
      if (w_idx >= (M+1)'(N)) begin
        w_idx = w_idx - (M+1)'(N);
      end
      if (!w_found && w_elig[w_idx[M-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[M-1:0];
      end
    end
  end

  assign w_ptrNext = (w_win == M'(N-1)) ? '0 : w_win + M'(1);

  // A winner is never a sink that is currently valid, so drain and load
  // never target the same entry in one cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= '0;
      r_data  <= '0;
      r_dest  <= '0;
      r_ptr   <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (r_valid[k] && i_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_valid[w_win] <= 1'b1;
        r_data[w_win]  <= i_data;
        r_dest         <= w_win;
        r_ptr          <= w_ptrNext;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dest  = r_dest;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Bench for rr_dispatcher: a 4-sink and a 6-sink instance run in lockstep
// against an array-based model of the round-robin dispatch rules.
module tb_rr_dispatcher;

  logic clk;
  logic rstn;
  logic [1:0]      v;
  logic [1:0][7:0] d;
  logic [1:0][7:0] msk;
  logic [1:0][7:0] rdy;

  logic            ready4;
  logic [3:0]      ov4;
  logic [3:0][7:0] od4;
  logic [1:0]      dest4;

  logic            ready6;
  logic [5:0]      ov6;
  logic [5:0][7:0] od6;
  logic [2:0]      dest6;

  int cmpCount  = 0;
  int failCount = 0;

  // Model state, indexed [instance][sink]
  int       nS[2] = '{4, 6};
  bit       mV[2][8];
  logic [7:0] mD[2][8];
  int       mPtr[2];
  int       mDest[2];

  rr_dispatcher #(.N(4), .DW(8)) dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v[0]), .i_data(d[0]), .o_ready(ready4),
    .i_mask(msk[0][3:0]), .o_valid(ov4), .o_data(od4), .i_ready(rdy[0][3:0]), .o_dest(dest4)
  );

  rr_dispatcher #(.N(6), .DW(8)) dut6 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(v[1]), .i_data(d[1]), .o_ready(ready6),
    .i_mask(msk[1][5:0]), .o_valid(ov6), .o_data(od6), .i_ready(rdy[1][5:0]), .o_dest(dest6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic getReady(int s);
    return (s == 1) ? ready6 : ready4;
  endfunction

  function automatic logic getValid(int s, int k);
    return (s == 1) ? ov6[k[2:0]] : ov4[k[1:0]];
  endfunction

  function automatic logic [7:0] getData(int s, int k);
    return (s == 1) ? od6[k[2:0]] : od4[k[1:0]];
  endfunction

  function automatic logic [31:0] getDest(int s);
    return (s == 1) ? {29'd0, dest6} : {30'd0, dest4};
  endfunction

  function automatic bit modelReady(int s);
    if (!rstn) return 1'b0;
    for (int k = 0; k < nS[s]; k++) begin
      if (!mV[s][k] && !msk[s][k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int modelWinner(int s);
    for (int i = 0; i < nS[s]; i++) begin
      int k;
      k = (mPtr[s] + i) % nS[s];
      if (!mV[s][k] && !msk[s][k]) return k;
    end
    return 0;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        mV[s][k] = 1'b0;
        mD[s][k] = 8'h00;
      end
      mPtr[s]  = 0;
      mDest[s] = 0;
    end
  endtask

  task automatic checkOutput();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < nS[s]; k++) begin
        check($sformatf("valid%0d[%0d]", s, k), getValid(s, k), mV[s][k]);
        check($sformatf("data%0d[%0d]", s, k), getData(s, k), mD[s][k]);
      end
      check($sformatf("dest%0d", s), getDest(s), mDest[s]);
    end
  endtask

  // One clock cycle using whatever inputs are currently driven.
  task automatic applyStimulus();
    bit acc[2];
    int win[2];
    bit drn[2][8];
    #1;
    for (int s = 0; s < 2; s++) begin
      bit er;
      er = modelReady(s);
      check($sformatf("ready%0d", s), getReady(s), er);
      acc[s] = v[s] && er;
      win[s] = acc[s] ? modelWinner(s) : 0;
      for (int k = 0; k < 8; k++) drn[s][k] = mV[s][k] && rdy[s][k];
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < nS[s]; k++) begin
        if (drn[s][k]) mV[s][k] = 1'b0;
      end
      if (acc[s]) begin
        mV[s][win[s]] = 1'b1;
        mD[s][win[s]] = d[s];
        mDest[s]      = win[s];
        mPtr[s]       = (win[s] + 1) % nS[s];
      end
    end
    checkOutput();
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic doReset();
    #3;
    rstn = 1'b0;
    modelReset();
    #1;
    check("rst_valid4", ov4, 4'h0);
    check("rst_valid6", ov6, 6'h0);
    check("rst_ready4", ready4, 1'b0);
    check("rst_ready6", ready6, 1'b0);
    check("rst_dest4", dest4, 2'd0);
    check("rst_dest6", dest6, 3'd0);
    check("rst_data4", od4, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idleAll();
    v   = '0;
    msk = '0;
    rdy = {8'hFF, 8'hFF};
  endtask

  initial begin
    rstn = 1'b0;
    v = '0; d = '0; msk = '0; rdy = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    check("init_ready4", ready4, 1'b0);
    check("init_ready6", ready6, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Back-to-back jobs, all sinks ready
    idleAll();
    for (int i = 0; i < 8; i++) begin
      v[0] = 1'b1; d[0] = 8'hD0 + 8'(i);
      applyStimulus();
      check("t1_dest", dest4, 32'(i % 4));
      check("t1_ready", ready4, 1'b1);
    end
    v[0] = 1'b0;
    applyStimulus();

    // Sinks stalled: fill, then free sink 2
    rdy[0] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1; d[0] = 8'h20 + 8'(i);
      applyStimulus();
      check("t2_dest", dest4, 32'(i));
    end
    check("t2_full", ready4, 1'b0);
    d[0] = 8'h24;
    applyStimulus();
    check("t2_hold_dest", dest4, 2'd3);
    v[0] = 1'b0; rdy[0] = 8'h04;
    applyStimulus();
    check("t2_drained", ov4[2], 1'b0);
    rdy[0] = 8'h00; v[0] = 1'b1; d[0] = 8'h55;
    applyStimulus();
    check("t2_refill_dest", dest4, 2'd2);
    check("t2_refill_data", od4[2], 8'h55);
    idleAll();
    applyStimulus();

    // Masked sinks 0 and 2
    doReset();
    idleAll();
    msk[0] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1; d[0] = 8'h30 + 8'(i);
      applyStimulus();
      check("t3_dest", dest4, (i % 2 == 0) ? 32'd1 : 32'd3);
      check("t3_masked", {ov4[2], ov4[0]}, 2'b00);
    end
    idleAll();
    applyStimulus();

    // Draining sink not reusable in the same cycle
    doReset();
    idleAll();
    rdy[0] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      v[0] = 1'b1; d[0] = 8'h40 + 8'(i);
      applyStimulus();
    end
    v[0] = 1'b0; rdy[0] = 8'h01;
    applyStimulus();
    rdy[0] = 8'h00; v[0] = 1'b1; d[0] = 8'h44;
    applyStimulus();
    check("t5_setup_dest", dest4, 2'd0);
    v[0] = 1'b0; rdy[0] = 8'h01;
    applyStimulus();
    v[0] = 1'b1; d[0] = 8'h45; rdy[0] = 8'h02;
    applyStimulus();
    check("t5_skip_dest", dest4, 2'd0);
    check("t5_sink1_free", ov4[1], 1'b0);
    rdy[0] = 8'h00; d[0] = 8'h46;
    applyStimulus();
    check("t5_next_dest", dest4, 2'd1);
    idleAll();
    applyStimulus();

    // Six sinks: wrap past a busy sink 5, non-power-of-two pointer
    doReset();
    idleAll();
    rdy[1] = 8'h1F;
    for (int i = 0; i < 11; i++) begin
      v[1] = 1'b1; d[1] = 8'h60 + 8'(i);
      applyStimulus();
      check("t4_fill_dest", dest6, 32'(i % 6));
    end
    d[1] = 8'h70;
    applyStimulus();
    check("t4_wrap_dest", dest6, 3'd0);
    v[1] = 1'b0; rdy[1] = 8'hFF;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      v[1] = 1'b1; d[1] = 8'h80 + 8'(i);
      applyStimulus();
      check("t4_seq_dest", dest6, 32'(i + 1));
    end
    idleAll();
    applyStimulus();

    // Reset with entries held
    rdy[0] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      v[0] = 1'b1; d[0] = 8'h90 + 8'(i);
      applyStimulus();
    end
    doReset();
    idleAll();
    v[0] = 1'b1; d[0] = 8'hA5;
    applyStimulus();
    check("t6_first_dest", dest4, 2'd0);
    check("t6_first_data", od4[0], 8'hA5);

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        doReset();
      end else begin
        for (int s = 0; s < 2; s++) begin
          v[s]   = 1'($urandom);
          d[s]   = 8'($urandom);
          msk[s] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
          rdy[s] = 8'($urandom);
        end
        applyStimulus();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
